// File: rtl/sa_cache_pkg.sv
// Shared types and sizing helpers for the set-associative cache refill controller.
package sa_cache_pkg;

  localparam int unsigned MAX_ADDR_W = 64;

  // Refill controller states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WB      = 3'd1,
    RD_REQ  = 3'd2,
    RD_DATA = 3'd3,
    FILL    = 3'd4
  } state_e;

  // Line size in bits.
  function automatic int unsigned calc_line_size_bits(input int unsigned line_bytes);
    return line_bytes * 8;
  endfunction

  // Number of bus beats per line.
  function automatic int unsigned calc_beats(input int unsigned line_bytes,
                                             input int unsigned data_width);
    return (line_bytes * 8) / data_width;
  endfunction

  // Byte-offset bits within a line.
  function automatic int unsigned calc_offset_bits(input int unsigned line_bytes);
    return $clog2(line_bytes);
  endfunction

  // Clear the in-line byte offset of an address.
  function automatic logic [MAX_ADDR_W-1:0] line_align(input logic [MAX_ADDR_W-1:0] addr,
                                                       input int unsigned offset_bits);
    logic [MAX_ADDR_W-1:0] mask;
    mask = ~((MAX_ADDR_W'(1) << offset_bits) - MAX_ADDR_W'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/sa_cache_line_buffer.sv
// Word-indexed line assembly buffer; line_c shows the stored words with any
// same-cycle write already merged in, so the final beat can be captured directly.
module sa_cache_line_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BEATS      = 16,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [IDX_W-1:0]              idx,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [BEATS*DATA_WIDTH-1:0]   line_c
);

  logic [BEATS-1:0][DATA_WIDTH-1:0] words;

  // Indexed word storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      words <= '0;
    end else if (we) begin
      words[idx] <= wdata;
    end
  end

  // Full line with pending write bypassed.
  always_comb begin
    line_c = words;
    if (we) begin
      line_c[idx*DATA_WIDTH +: DATA_WIDTH] = wdata;
    end
  end

endmodule

// File: rtl/sa_cache_refill_ctrl.sv
// Miss handler for the 4-way set-associative cache: optional dirty-victim
// writeback, beat-wise line fetch, single-cycle fill strobe.
// Optional perf counters (o_miss_count, o_wb_count) under SA_CACHE_CTRL_PERF_EN.
module sa_cache_refill_ctrl
  import sa_cache_pkg::*;
#(
  parameter int unsigned LINE_SIZE_BYTES = 64,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned ADDRESS_WIDTH   = 32,
  parameter int unsigned WAYS            = 4,
  localparam int unsigned LINE_SIZE_BITS = calc_line_size_bits(LINE_SIZE_BYTES),
  localparam int unsigned WAY_W          = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_miss_valid,
  output logic                      o_miss_ready,
  input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
  input  logic [WAY_W-1:0]          i_miss_way,
  input  logic                      i_evict_dirty,
  input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
  input  logic [LINE_SIZE_BITS-1:0] i_evict_line,
  output logic                      o_fill_valid,
  output logic [WAY_W-1:0]          o_fill_way,
  output logic [LINE_SIZE_BITS-1:0] o_fill_line,
  output logic                      o_busy,
  output logic                      o_mem_valid,
  output logic                      o_mem_we,
  output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  input  logic                      i_mem_ready,
  input  logic                      i_mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     i_mem_rdata
`ifdef SA_CACHE_CTRL_PERF_EN
  ,
  output logic [31:0]               o_miss_count,
  output logic [31:0]               o_wb_count
`endif
);

  localparam int unsigned BEATS       = calc_beats(LINE_SIZE_BYTES, DATA_WIDTH);
  localparam int unsigned OFFSET_BITS = calc_offset_bits(LINE_SIZE_BYTES);
  localparam int unsigned BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WORD_BYTES  = DATA_WIDTH / 8;

  state_e                      state;
  logic [BEAT_W-1:0]           beat;
  logic [ADDRESS_WIDTH-1:0]    miss_base_q;
  logic [ADDRESS_WIDTH-1:0]    evict_base_q;
  logic [WAY_W-1:0]            way_q;
  logic [LINE_SIZE_BITS-1:0]   evict_line_q;

  logic                        accept_c;
  logic                        mem_hs_c;
  logic                        buf_we_c;
  logic                        last_beat_c;
  logic [BEAT_W-1:0]           beat_nxt_c;
  logic [ADDRESS_WIDTH-1:0]    miss_base_c;
  logic [ADDRESS_WIDTH-1:0]    evict_base_c;
  logic [ADDRESS_WIDTH-1:0]    wb_addr_nxt_c;
  logic [DATA_WIDTH-1:0]       wb_data_nxt_c;
  logic [LINE_SIZE_BITS-1:0]   line_c;

  // Handshakes, aligned bases and next writeback beat.
  always_comb begin
    accept_c      = i_miss_valid & o_miss_ready;
    mem_hs_c      = o_mem_valid & i_mem_ready;
    buf_we_c      = (state == RD_DATA) & i_mem_rvalid;
    last_beat_c   = (beat == BEAT_W'(BEATS - 1));
    beat_nxt_c    = beat + BEAT_W'(1);
    miss_base_c   = ADDRESS_WIDTH'(line_align(MAX_ADDR_W'(i_miss_addr), OFFSET_BITS));
    evict_base_c  = ADDRESS_WIDTH'(line_align(MAX_ADDR_W'(i_evict_addr), OFFSET_BITS));
    wb_addr_nxt_c = evict_base_q + ADDRESS_WIDTH'(beat_nxt_c) * ADDRESS_WIDTH'(WORD_BYTES);
    wb_data_nxt_c = evict_line_q[beat_nxt_c*DATA_WIDTH +: DATA_WIDTH];
  end

  sa_cache_line_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BEATS      (BEATS),
    .IDX_W      (BEAT_W)
  ) u_line_buffer (
    .clk    (clk),
    .rst    (rst),
    .we     (buf_we_c),
    .idx    (beat),
    .wdata  (i_mem_rdata),
    .line_c (line_c)
  );

  // Refill FSM with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      beat         <= '0;
      miss_base_q  <= '0;
      evict_base_q <= '0;
      way_q        <= '0;
      evict_line_q <= '0;
      o_miss_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_mem_valid  <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_wdata  <= '0;
      o_fill_valid <= 1'b0;
      o_fill_way   <= '0;
      o_fill_line  <= '0;
    end else begin
      case (state)
        IDLE: begin
          o_miss_ready <= 1'b1;
          if (accept_c) begin
            o_miss_ready <= 1'b0;
            o_busy       <= 1'b1;
            miss_base_q  <= miss_base_c;
            evict_base_q <= evict_base_c;
            way_q        <= i_miss_way;
            evict_line_q <= i_evict_line;
            beat         <= '0;
            o_mem_valid  <= 1'b1;
            if (i_evict_dirty) begin
              state       <= WB;
              o_mem_we    <= 1'b1;
              o_mem_addr  <= evict_base_c;
              o_mem_wdata <= i_evict_line[DATA_WIDTH-1:0];
            end else begin
              state       <= RD_REQ;
              o_mem_we    <= 1'b0;
              o_mem_addr  <= miss_base_c;
              o_mem_wdata <= '0;
            end
          end
        end
        WB: begin
          if (mem_hs_c) begin
            if (last_beat_c) begin
              beat        <= '0;
              state       <= RD_REQ;
              o_mem_we    <= 1'b0;
              o_mem_addr  <= miss_base_q;
              o_mem_wdata <= '0;
            end else begin
              beat        <= beat_nxt_c;
              o_mem_addr  <= wb_addr_nxt_c;
              o_mem_wdata <= wb_data_nxt_c;
            end
          end
        end
        RD_REQ: begin
          if (mem_hs_c) begin
            o_mem_valid <= 1'b0;
            o_mem_addr  <= '0;
            beat        <= '0;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (i_mem_rvalid) begin
            if (last_beat_c) begin
              beat         <= '0;
              state        <= FILL;
              o_fill_valid <= 1'b1;
              o_fill_way   <= way_q;
              o_fill_line  <= line_c;
            end else begin
              beat <= beat_nxt_c;
            end
          end
        end
        FILL: begin
          o_fill_valid <= 1'b0;
          o_busy       <= 1'b0;
          o_miss_ready <= 1'b1;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SA_CACHE_CTRL_PERF_EN
  // Saturating miss and writeback counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_miss_count <= '0;
      o_wb_count   <= '0;
    end else if (accept_c) begin
      if (o_miss_count != '1) begin
        o_miss_count <= o_miss_count + 32'd1;
      end
      if (i_evict_dirty && (o_wb_count != '1)) begin
        o_wb_count <= o_wb_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: doc/sa_cache_refill_ctrl.md
Name: sa_cache_refill_ctrl

Overview:
Miss-handling controller for the 4-way set-associative cache.
- Accepts one miss at a time from the cache.
- If the victim way is dirty, writes the victim line back to memory over a word-wide bus as a beat sequence.
- Fetches the missing line beat by beat, then hands the assembled line to the cache with a one-cycle fill strobe.
- Sits between the cache array and the memory port; it is the only block that drives memory traffic for the cache.

Parameters:
- LINE_SIZE_BYTES, 64, cache line size in bytes.
- DATA_WIDTH, 32, memory bus word width in bits; must divide LINE_SIZE_BYTES*8.
- ADDRESS_WIDTH, 32, byte address width.
- WAYS, 4, associativity; sets the width of the way tag.
- Derived localparams: LINE_SIZE_BITS = LINE_SIZE_BYTES*8; BEATS = LINE_SIZE_BITS/DATA_WIDTH (default 16); OFFSET_BITS = clog2(LINE_SIZE_BYTES).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_miss_valid  in  1  miss request; held high until accepted.
- o_miss_ready  out  1  high only in IDLE; accept = i_miss_valid & o_miss_ready.
- i_miss_addr  in  ADDRESS_WIDTH  address that missed.
- i_miss_way  in  clog2(WAYS)  victim way chosen by the cache.
- i_evict_dirty  in  1  victim line is valid and dirty.
- i_evict_addr  in  ADDRESS_WIDTH  victim line address.
- i_evict_line  in  LINE_SIZE_BITS  victim line data.
- o_fill_valid  out  1  one-cycle strobe: refill line ready.
- o_fill_way  out  clog2(WAYS)  captured victim way.
- o_fill_line  out  LINE_SIZE_BITS  assembled refill line.
- o_busy  out  1  state != IDLE.
- o_mem_valid  out  1  memory request valid.
- o_mem_we  out  1  1 = write beat, 0 = line read request.
- o_mem_addr  out  ADDRESS_WIDTH  request byte address.
- o_mem_wdata  out  DATA_WIDTH  write beat data.
- i_mem_ready  in  1  memory accepts request this cycle.
- i_mem_rvalid  in  1  read beat valid; no backpressure.
- i_mem_rdata  in  DATA_WIDTH  read beat data.

Behaviour:
- Reset (rst low, asynchronous):
  - State returns to IDLE; beat counter = 0.
  - All outputs 0, including o_fill_line.
  - Any outstanding memory transaction is abandoned; rvalid beats arriving after reset are ignored (not in RD_DATA).
- Capture on accept:
  - Register miss_addr and evict_addr line-aligned (low OFFSET_BITS forced to 0).
  - Register way, dirty flag and evict_line.
  - Next state: WB if dirty, else RD_REQ.
- WB:
  - o_mem_valid=1, o_mem_we=1.
  - o_mem_addr = evict_base + beat*(DATA_WIDTH/8), computed modulo 2^ADDRESS_WIDTH.
  - o_mem_wdata = evict_line[beat*DATA_WIDTH +: DATA_WIDTH].
  - Beat increments on each handshake (o_mem_valid & i_mem_ready).
  - On the handshake of beat BEATS-1: beat=0, next state RD_REQ.
  - Valid, address and data stay stable while i_mem_ready is low.
- RD_REQ:
  - o_mem_valid=1, o_mem_we=0, o_mem_addr = miss_base.
  - On handshake: next state RD_DATA, beat=0.
- RD_DATA:
  - o_mem_valid=0.
  - Each i_mem_rvalid writes i_mem_rdata into word slot[beat] and increments beat.
  - Gaps between beats are allowed.
  - When beat BEATS-1 is written: next state FILL.
- FILL:
  - o_fill_valid=1 for exactly one cycle, with o_fill_line and o_fill_way valid.
  - Next state IDLE.
  - o_fill_line and o_fill_way hold their values until the next fill.
- IDLE is re-entered the cycle after FILL, so a new miss can be accepted then; no back-to-back overlap of misses.
- i_mem_rvalid in any state other than RD_DATA is ignored.
- Miss inputs are sampled only at accept; later changes have no effect.
- Latency, clean miss with zero-wait memory:
  - accept at cycle T;
  - read request handshake at T+1;
  - beats at T+2 .. T+1+BEATS;
  - o_fill_valid at T+2+BEATS.
- A dirty miss adds BEATS write handshake cycles before RD_REQ.

Optional Feature:
- Macro: SA_CACHE_CTRL_PERF_EN.
- When defined:
  - Adds output o_miss_count (32 bits), incremented on each accept.
  - Adds output o_wb_count (32 bits), incremented on each WB entry.
  - Both counters saturate at all-ones and reset to 0.
- When undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package sa_cache_pkg holds:
  - the state enum: IDLE, WB, RD_REQ, RD_DATA, FILL;
  - the LINE_SIZE_BITS, BEATS and OFFSET_BITS calculation functions;
  - the line-align helper.
- One sub-module, sa_cache_line_buffer:
  - BEATS x DATA_WIDTH registers with indexed word write and a full-line output;
  - used for refill assembly.
- Writeback data is sliced directly from the captured evict line.

Test Plan:
- Clean miss: addr 0x0000_1234, dirty=0, memory always ready, rdata = beat index -> read request at address 0x0000_1200; fill line words 0..15 = 0..15; o_fill_valid at T+18.
- Dirty miss: evict_addr 0x0000_8040, way 2, line word k = 0xA000_0000+k -> 16 writes at 0x8040..0x807C with matching data, then read request, o_fill_way=2.
- Backpressure: i_mem_ready low for 3 cycles on WB beat 5 -> address and data held stable, no duplicate or skipped beat.
- Rvalid gaps plus a stray rvalid issued in IDLE -> stray beat ignored; line assembled correctly despite gaps.
- Reset asserted during RD_DATA at beat 7 -> all outputs 0 immediately, IDLE; subsequent rvalid beats ignored; next miss completes normally.
- Wrap-around: evict_addr 0xFFFF_FFC0, dirty -> beat addresses 0xFFFF_FFC0..0xFFFF_FFFC, no overflow into the upper bits.
